ps2_hex_entry: RTL and testbench

- PS/2 keyboard receiver plus hex-digit entry logic for the calculator front end.
- Deserialises device-to-host PS/2 frames and decodes set-2 scan codes into 4-bit hex digits.
- Assembles digits into a 16-bit entry register.
- On Enter, commits the entry as the 16-bit value and display strobe consumed by the seven-segment display driver.

---
 rtl/ps2_pkg.sv | 44 ++++
 rtl/ps2_rx_frame.sv | 119 +++++++++++
 rtl/ps2_hex_entry.sv | 88 ++++++++
 tb/tb_ps2_hex_entry.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types, scan-code constants and the set-2 scan-code to hex-digit lookup
// for the PS/2 hex entry front end.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Returns {hit, nibble}; hit is 0 for anything that is not a hex-digit make code.
  function automatic logic [4:0] scan_to_hex(input logic [7:0] code);
    logic [4:0] r;
    r = 5'h00;
    case (code)
      8'h45: r = {1'b1, 4'h0};
      8'h16: r = {1'b1, 4'h1};
      8'h1E: r = {1'b1, 4'h2};
      8'h26: r = {1'b1, 4'h3};
      8'h25: r = {1'b1, 4'h4};
      8'h2E: r = {1'b1, 4'h5};
      8'h36: r = {1'b1, 4'h6};
      8'h3D: r = {1'b1, 4'h7};
      8'h3E: r = {1'b1, 4'h8};
      8'h46: r = {1'b1, 4'h9};
      8'h1C: r = {1'b1, 4'hA};
      8'h32: r = {1'b1, 4'hB};
      8'h21: r = {1'b1, 4'hC};
      8'h23: r = {1'b1, 4'hD};
      8'h24: r = {1'b1, 4'hE};
      8'h2B: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: synchronisers, ps2_clk glitch filter, frame FSM
// and partial-frame timeout. Emits a one-cycle byte_valid per good frame.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (data 0 on a bit strobe)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking stop bit and parity, then back to idle
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN = 8,
  parameter int unsigned TIMEOUT  = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [FW-1:0] FILT_TOP = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TO_TOP   = TW'(TIMEOUT - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          bit_strobe;
  logic          sdata;

  frame_state_e  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;

  assign sdata      = dat_sync[1];
  // Strobe in the same cycle the filtered level drops from 1 to 0.
  assign bit_strobe = filt_clk && !clk_sync[1] && (filt_cnt == '0);
  assign rx_byte    = shreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_clk <= 1'b1;
      filt_cnt <= FILT_TOP;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= FILT_TOP;
      end else if (filt_cnt == '0) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= FILT_TOP;
      end else begin
        filt_cnt <= filt_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= TO_TOP;
    end else if (state == ST_IDLE || bit_strobe) begin
      to_cnt <= TO_TOP;
    end else if (to_cnt != '0) begin
      to_cnt <= to_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state != ST_IDLE && !bit_strobe && to_cnt == '0) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
      end else if (bit_strobe) begin
        case (state)
          ST_IDLE: begin
            if (!sdata) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            shreg   <= {sdata, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= sdata;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            if (sdata && (^{shreg, par_bit})) byte_valid <= 1'b1;
            else                               frame_err  <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_hex_entry.sv
// PS/2 hex entry front end: scan-code layer on top of the frame receiver,
// building a 16-bit entry and committing it to number on Enter.
module ps2_hex_entry
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN = 8,
  parameter int unsigned TIMEOUT  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] entry,
  output logic [15:0] number,
  output logic        number_valid,
  output logic        key_valid,
  output logic        frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       brk;
  logic       ext;
  logic [4:0] hex;

  ps2_rx_frame #(
    .FILT_LEN (FILT_LEN),
    .TIMEOUT  (TIMEOUT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign hex = scan_to_hex(rx_byte);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry        <= 16'h0000;
      number       <= 16'h0000;
      number_valid <= 1'b0;
      key_valid    <= 1'b0;
      brk          <= 1'b0;
      ext          <= 1'b0;
    end else begin
      number_valid <= 1'b0;
      key_valid    <= 1'b0;
      if (byte_valid) begin
        if (rx_byte == SC_BREAK) begin
          brk <= 1'b1;
        end else if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (brk) begin
          brk <= 1'b0;
          ext <= 1'b0;
        end else if (ext) begin
          // Only keypad Enter is meaningful among extended keys.
          ext <= 1'b0;
          if (rx_byte == SC_ENTER) begin
            number       <= entry;
            entry        <= 16'h0000;
            number_valid <= 1'b1;
            key_valid    <= 1'b1;
          end
        end else if (hex[4]) begin
          entry     <= {entry[11:0], hex[3:0]};
          key_valid <= 1'b1;
        end else if (rx_byte == SC_BKSP) begin
          entry     <= {4'h0, entry[15:4]};
          key_valid <= 1'b1;
        end else if (rx_byte == SC_ESC) begin
          entry     <= 16'h0000;
          key_valid <= 1'b1;
        end else if (rx_byte == SC_ENTER) begin
          number       <= entry;
          entry        <= 16'h0000;
          number_valid <= 1'b1;
          key_valid    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Directed bench for ps2_hex_entry: drives PS/2 frames bit by bit and checks
// entry/number contents and pulse counts against hand-computed values.
module tb_ps2_hex_entry;

  localparam int HALF    = 20;
  localparam int TIMEOUT = 2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] entry;
  logic [15:0] number;
  logic        number_valid;
  logic        key_valid;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int kv_cnt = 0;
  int nv_cnt = 0;
  int fe_cnt = 0;
  int kv0, nv0, fe0;

  ps2_hex_entry #(
    .FILT_LEN (8),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .entry        (entry),
    .number       (number),
    .number_valid (number_valid),
    .key_valid    (key_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid)    kv_cnt++;
    if (number_valid) nv_cnt++;
    if (frame_err)    fe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Drives the first n bits of an 11-bit frame; optional 3-cycle low glitch in bit 3's high phase.
  task automatic ps2_bits(input logic [10:0] bits, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (glitch && i == 3) begin
        cycles(6);
        ps2_clk = 1'b0;
        cycles(3);
        ps2_clk = 1'b1;
        cycles(HALF - 9);
      end else begin
        cycles(HALF);
      end
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bits({~bad_stop, par, b, 1'b0}, 11, glitch);
    ps2_data = 1'b1;
    cycles(4 * HALF);
  endtask

  task automatic key(input logic [7:0] b);
    send(b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mark();
    kv0 = kv_cnt;
    nv0 = nv_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cycles(5);
    @(negedge clk);
    chk("rst_entry", entry, 0);
    chk("rst_number", number, 0);
    chk("rst_pulses", {number_valid, key_valid, frame_err}, 0);
    reset = 1'b1;
    cycles(10);

    mark();
    key(8'h16); key(8'hF0); key(8'h16);
    key(8'h1E); key(8'hF0); key(8'h1E);
    key(8'h26); key(8'hF0); key(8'h26);
    key(8'h25); key(8'hF0); key(8'h25);
    chk("digits_entry", entry, 16'h1234);
    chk("digits_kv", kv_cnt - kv0, 4);
    chk("digits_number", number, 0);
    chk("digits_fe", fe_cnt - fe0, 0);

    mark();
    key(8'h5A); key(8'hF0); key(8'h5A);
    chk("enter_number", number, 16'h1234);
    chk("enter_nv", nv_cnt - nv0, 1);
    chk("enter_entry", entry, 0);

    key(8'h1C); key(8'h32); key(8'h21); key(8'h23); key(8'h24);
    chk("hex_shift", entry, 16'hBCDE);
    key(8'h66);
    chk("bksp", entry, 16'h0BCD);
    key(8'h76);
    chk("esc", entry, 0);

    mark();
    send(8'h45, 1'b1, 1'b0, 1'b0);
    chk("par_fe", fe_cnt - fe0, 1);
    chk("par_entry", entry, 0);
    chk("par_kv", kv_cnt - kv0, 0);
    mark();
    send(8'h16, 1'b0, 1'b1, 1'b0);
    chk("stop_fe", fe_cnt - fe0, 1);
    chk("stop_entry", entry, 0);

    mark();
    send(8'h1E, 1'b0, 1'b0, 1'b1);
    chk("glitch_entry", entry, 16'h0002);
    chk("glitch_fe", fe_cnt - fe0, 0);
    key(8'hF0); key(8'h1E); key(8'h76);
    chk("glitch_clr", entry, 0);

    mark();
    ps2_bits({1'b1, 1'b0, 8'h16, 1'b0}, 6, 1'b0);
    ps2_data = 1'b1;
    cycles(TIMEOUT - 300);
    chk("to_early", fe_cnt - fe0, 0);
    cycles(400);
    chk("to_fe", fe_cnt - fe0, 1);
    key(8'h16);
    chk("to_next", entry, 16'h0001);

    key(8'h76); key(8'h1C); key(8'h32);
    chk("pre_rst", entry, 16'h00AB);
    ps2_bits({1'b1, 1'b0, 8'h16, 1'b0}, 4, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_entry", entry, 0);
    chk("mid_rst_number", number, 0);
    chk("mid_rst_pulses", {number_valid, key_valid, frame_err}, 0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cycles(5);
    reset = 1'b1;
    cycles(20);

    mark();
    key(8'hE0); key(8'h5A);
    chk("kp_enter_nv", nv_cnt - nv0, 1);
    chk("kp_enter_num", number, 0);
    chk("kp_enter_kv", kv_cnt - kv0, 1);
    mark();
    key(8'hE0); key(8'h16);
    chk("ext_ign_entry", entry, 0);
    chk("ext_ign_kv", kv_cnt - kv0, 0);
    chk("final_fe", fe_cnt - fe0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
